// File: rtl/operand_store.sv
// Write-back stage: retires an execution result to the register file or to data memory.
// It applies byte/word lane rules and performs the SP pre-decrement for PUSH/CALL.
module operand_store #(
    parameter int WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] Result,
    input  logic [15:0] DstAddr,
    input  logic [3:0]  DstReg,
    input  logic        DstMem,
    input  logic        BW,
    input  logic        Push,
    input  logic [15:0] SP,
    input  logic        MemRdy,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        Unaligned,
    output logic        RegWrEn,
    output logic [3:0]  RegWrIdx,
    output logic [15:0] RegWrData,
    output logic [15:0] MAB,
    output logic [15:0] MDBout,
    output logic        MW,
    output logic [1:0]  MBE,
    output logic [2:0]  stateDbg
);

    // Handshake: start is a one-cycle request honoured only in IDLE; busy stays high
    // from the edge after start through DONE; done pulses once with err/Unaligned valid.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        WSP  = 3'd1,
        WREG = 3'd2,
        WMEM = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [3:0] WAIT_LIM = 4'(WAIT_MAX);

    state_t      state;
    logic [15:0] resQ;
    logic [15:0] addrQ;
    logic        bwQ;
    logic        unalQ;
    logic [3:0]  waitCnt;

    logic [15:0] srcAddr;
    logic [15:0] srcRes;
    logic        srcBW;
    logic [15:0] mabNext;
    logic [15:0] mdbNext;
    logic [1:0]  mbeNext;
    logic        unalNext;
    logic [15:0] spDec;

    assign stateDbg = state;
    assign spDec    = SP - 16'd2;

    // Memory lanes are derived from live inputs on a direct entry from IDLE, and from
    // the captured (already SP-decremented) values when arriving from WSP.
    always_comb begin
        if (state == IDLE) begin
            srcAddr = DstAddr;
            srcRes  = Result;
            srcBW   = BW;
        end else begin
            srcAddr = addrQ;
            srcRes  = resQ;
            srcBW   = bwQ;
        end
        mabNext  = srcBW ? srcAddr : {srcAddr[15:1], 1'b0};
        mdbNext  = srcBW ? {srcRes[7:0], srcRes[7:0]} : srcRes;
        mbeNext  = srcBW ? (srcAddr[0] ? 2'b10 : 2'b01) : 2'b11;
        unalNext = ~srcBW & srcAddr[0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            resQ      <= 16'h0000;
            addrQ     <= 16'h0000;
            bwQ       <= 1'b0;
            unalQ     <= 1'b0;
            waitCnt   <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            Unaligned <= 1'b0;
            RegWrEn   <= 1'b0;
            RegWrIdx  <= 4'd0;
            RegWrData <= 16'h0000;
            MAB       <= 16'h0000;
            MDBout    <= 16'h0000;
            MW        <= 1'b0;
            MBE       <= 2'b00;
        end else begin
            RegWrEn   <= 1'b0;
            MW        <= 1'b0;
            MBE       <= 2'b00;
            done      <= 1'b0;
            err       <= 1'b0;
            Unaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        resQ  <= Result;
                        addrQ <= DstAddr;
                        bwQ   <= BW;
                        if (Push) begin
                            state     <= WSP;
                            addrQ     <= spDec;
                            RegWrEn   <= 1'b1;
                            RegWrIdx  <= 4'd1;
                            RegWrData <= spDec;
                        end else if (DstMem) begin
                            state   <= WMEM;
                            waitCnt <= 4'd0;
                            MW      <= 1'b1;
                            MAB     <= mabNext;
                            MDBout  <= mdbNext;
                            MBE     <= mbeNext;
                            unalQ   <= unalNext;
                        end else begin
                            state     <= WREG;
                            RegWrEn   <= 1'b1;
                            RegWrIdx  <= DstReg;
                            RegWrData <= BW ? {8'h00, Result[7:0]} : Result;
                        end
                    end
                end
                WSP: begin
                    state   <= WMEM;
                    waitCnt <= 4'd0;
                    MW      <= 1'b1;
                    MAB     <= mabNext;
                    MDBout  <= mdbNext;
                    MBE     <= mbeNext;
                    unalQ   <= unalNext;
                end
                WREG: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                WMEM: begin
                    if (MemRdy) begin
                        state     <= DONE;
                        done      <= 1'b1;
                        Unaligned <= unalQ;
                    end else if (waitCnt == WAIT_LIM) begin
                        // Memory never answered: abort without retry.
                        state     <= DONE;
                        done      <= 1'b1;
                        err       <= 1'b1;
                        Unaligned <= unalQ;
                    end else begin
                        MW      <= 1'b1;
                        MBE     <= MBE;
                        waitCnt <= waitCnt + 4'd1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/operand_store.md
# operand_store

Result write-back unit for the MSP430 CPU core, and the write-side counterpart of the operand fetch stage. It takes the execution result plus destination descriptor and retires it either to the register file (single write port) or to data memory over the MAB/MDB bus. It applies MSP430 byte/word rules and performs the SP pre-decrement for PUSH/CALL. A start/busy/done handshake lets the control FSM stall until the write has retired.

## Interface
- WAIT_MAX, 15: maximum MemRdy-low cycles tolerated in a memory write before abort (4-bit wait counter).
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on the rising clk edge.
- start  in  1  one-cycle request; sampled only in IDLE, ignored while busy.
- Result  in  16  value to store.
- DstAddr  in  16  effective destination address (memory destinations).
- DstReg  in  4  destination register index (register destinations).
- DstMem  in  1  1 = memory destination, 0 = register destination.
- BW  in  1  1 = byte operation, 0 = word.
- Push  in  1  stack push; overrides DstMem/DstAddr/DstReg.
- SP  in  16  current R1 value.
- MemRdy  in  1  memory accepts the write in the cycle it is high while MW = 1.
- busy  out  1  high in every non-IDLE state.
- done  out  1  one-cycle completion pulse.
- err  out  1  valid with done; 1 = aborted on wait timeout.
- Unaligned  out  1  valid with done; 1 = word write to an odd address.
- RegWrEn  out  1  register-file write strobe.
- RegWrIdx  out  4  register-file write index.
- RegWrData  out  16  register-file write data.
- MAB  out  16  memory address.
- MDBout  out  16  memory write data.
- MW  out  1  memory write strobe.
- MBE  out  2  byte enables: [1] = high byte, [0] = low byte.

## Operation
- States: IDLE, WSP, WREG, WMEM, DONE. All outputs are registered.
- The start edge in IDLE captures all inputs. The next state is:
  - WSP if Push = 1;
  - otherwise WMEM if DstMem = 1;
  - otherwise WREG.
- WREG (one cycle):
  - RegWrEn = 1, RegWrIdx = DstReg.
  - RegWrData = Result for a word op, {8'h00, Result[7:0]} for a byte op (byte ops clear the high byte).
  - Next state: DONE.
- WSP (one cycle):
  - RegWrEn = 1, RegWrIdx = 4'd1, RegWrData = SP − 2 (mod 2^16), for both byte and word pushes.
  - The captured write address becomes SP − 2.
  - Next state: WMEM.
- WMEM:
  - MW = 1. The state is held until MemRdy is sampled high, then goes to DONE.
  - Word write: MAB = {addr[15:1], 1'b0}, MBE = 2'b11, MDBout = Result. Unaligned = addr[0].
  - Byte write: MAB = addr, MDBout = {Result[7:0], Result[7:0]}, MBE = addr[0] ? 2'b10 : 2'b01.
- Wait counter:
  - Cleared on entry to WMEM; increments each WMEM cycle with MemRdy low.
  - When the count reaches WAIT_MAX with MemRdy still low, the next state is DONE with err = 1 and MW dropped. No retry.
- DONE (one cycle): done = 1, with err and Unaligned valid; all strobes low. Next state: IDLE.
- In every other cycle RegWrEn, MW, MBE, done, err and Unaligned are 0.

## Timing
- Reset (rst = 0 at an edge): state goes to IDLE, and every output is 0 after that edge.
  - This includes MAB, MDBout, RegWrData, RegWrIdx and MBE.
  - Reset mid-WMEM drops MW the next cycle; no done is produced.
- Cycle counts, for start sampled at edge k:
  - Register destination: RegWrEn high during cycle k→k+1; done during k+1→k+2.
  - Memory destination with MemRdy already high: MW high during cycle k→k+1; done at k+1.
  - Each MemRdy-low cycle adds one cycle.
  - Push: WSP at k, WMEM at k+1, done at k+2 (MemRdy high).
- Handshake:
  - busy rises on the edge after start; it is low in IDLE and high in DONE.
  - A start in DONE is ignored. A new start is accepted only from the IDLE cycle after done.
- MemRdy sampled high coincides with the write; MW deasserts the next cycle.
- Timeout: MW is held for WAIT_MAX+1 cycles, then done/err pulse.
- Push with SP = 16'h0000: the address wraps to 16'hFFFE.

## Test plan
- Word register write: Result = 16'hA5C3, DstReg = 5, BW = 0, start → RegWrEn one cycle, RegWrIdx = 5, RegWrData = 16'hA5C3; done one cycle later; no MW.
- Byte register write: Result = 16'hA5C3, BW = 1 → RegWrData = 16'h00C3.
- Memory byte writes, MemRdy = 1:
  - DstAddr = 16'h0201, Result = 16'h1234 → MAB = 16'h0201, MDBout = 16'h3434, MBE = 2'b10.
  - DstAddr = 16'h0200 → MBE = 2'b01.
- Word to odd address, with MemRdy low 3 cycles: DstAddr = 16'h0301 → MAB = 16'h0300, MBE = 2'b11, MW held 4 cycles; done with Unaligned = 1, err = 0.
- Push: SP = 16'h0400, Result = 16'hBEEF → R1 ← 16'h03FE, then MW at MAB = 16'h03FE; done 3 cycles after start.
- Timeout and reset:
  - MemRdy stuck 0 → done with err = 1 after WAIT_MAX+1 MW cycles.
  - Repeat with rst = 0 mid-WMEM → all outputs 0, no done.
  - A start issued during busy is ignored.
